// File: rtl/qn_readout_pkg.sv
// Shared definitions for the event readout sequencer.
//   state_t      : sequencer FSM states (exposed as the `state` register in the top)
//   ID_HEADER    : id byte of the per-event header word
//   ID_TRAILER   : id byte of the per-event trailer word
//   pack_word()  : builds a FIFO word {payload, id}; callers truncate to their word width
package qn_readout_pkg;

    localparam int ID_W          = 8;
    localparam int PAYLOAD_MAX_W = 32;   // widest TIME_W the helper supports

    localparam logic [ID_W-1:0] ID_HEADER  = 8'hFE;
    localparam logic [ID_W-1:0] ID_TRAILER = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WINDOW  = 3'd1,
        ST_CHECK   = 3'd2,
        ST_HEADER  = 3'd3,
        ST_SCAN    = 3'd4,
        ST_TRAILER = 3'd5,
        ST_CLEAR   = 3'd6
    } state_t;

    function automatic logic [PAYLOAD_MAX_W+ID_W-1:0] pack_word(
        input logic [PAYLOAD_MAX_W-1:0] payload,
        input logic [ID_W-1:0]          id
    );
        return {payload, id};
    endfunction

endpackage

// File: rtl/chan_select.sv
// Combinational channel selector for the readout scan.
//   idx      in  8              scan index; values >= N_CH select nothing (outputs 0)
//   ch_hit   in  N_CH           per-channel time-valid flags
//   ch_time  in  N_CH*TIME_W    per-channel hit times, channel i at [i*TIME_W +: TIME_W]
//   sel_hit  out 1              ch_hit[idx]
//   sel_time out TIME_W         time of channel idx
module chan_select #(
    parameter int N_CH   = 32,
    parameter int TIME_W = 8
) (
    input  logic [7:0]             idx,
    input  logic [N_CH-1:0]        ch_hit,
    input  logic [N_CH*TIME_W-1:0] ch_time,
    output logic                   sel_hit,
    output logic [TIME_W-1:0]      sel_time
);

    always_comb begin
        sel_hit  = 1'b0;
        sel_time = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (idx == 8'(i)) begin
                sel_hit  = ch_hit[i];
                sel_time = ch_time[i*TIME_W +: TIME_W];
            end
        end
    end

endmodule

// File: rtl/event_readout_seq.sv
// Event readout sequencer: on a trigger edge opens the capture gate, then
// serialises every channel's hit time into the readout FIFO as
// header / data / trailer words, followed by a tube clear pulse.
//   clk50      in  1             system clock (posedge)
//   rst        in  1             synchronous active-high reset
//   trig       in  1             trigger; rising edge accepted only when idle
//   zs_en      in  1             zero suppression, latched on trigger acceptance
//   ch_hit     in  N_CH          per-channel time-valid flags
//   ch_time    in  N_CH*TIME_W   per-channel hit times
//   fifo_space in  SPACE_W       free words in the readout FIFO
//   fifo_full  in  1             readout FIFO full
//   gate       out 1             capture window
//   tube_clr   out 1             clear pulse to the tube channels
//   fifo_din   out TIME_W+8      FIFO word {payload, id}
//   fifo_wr_en out 1             FIFO write strobe
//   busy       out 1             sequencer not idle
//   overflow   out 1             sticky: a write happened while fifo_full was high
//   drop_cnt   out 16            saturating count of events dropped for lack of space
//
// FIFO interface: write-only, no back-pressure. A word is transferred in every
// cycle fifo_wr_en is high; fifo_din is only meaningful in those cycles and
// holds its last value otherwise. fifo_full never stalls the sequencer, it
// only sets overflow.
module event_readout_seq
    import qn_readout_pkg::*;
#(
    parameter int N_CH       = 32,
    parameter int TIME_W     = 8,
    parameter int WINDOW_CYC = 256,
    parameter int CLR_CYC    = 11,
    parameter int SPACE_W    = 10
) (
    input  logic                   clk50,
    input  logic                   rst,
    input  logic                   trig,
    input  logic                   zs_en,
    input  logic [N_CH-1:0]        ch_hit,
    input  logic [N_CH*TIME_W-1:0] ch_time,
    input  logic [SPACE_W-1:0]     fifo_space,
    input  logic                   fifo_full,
    output logic                   gate,
    output logic                   tube_clr,
    output logic [TIME_W+7:0]      fifo_din,
    output logic                   fifo_wr_en,
    output logic                   busy,
    output logic                   overflow,
    output logic [15:0]            drop_cnt
);

    localparam int WORD_W  = TIME_W + ID_W;
    localparam int CNT_MAX = (WINDOW_CYC > CLR_CYC) ? WINDOW_CYC : CLR_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   WIN_LOAD  = CNT_W'(WINDOW_CYC - 1);
    localparam logic [CNT_W-1:0]   CLR_LOAD  = CNT_W'(CLR_CYC - 1);
    localparam logic [SPACE_W:0]   MIN_SPACE = (SPACE_W+1)'(N_CH + 2);
    localparam logic [7:0]         SEL_END   = 8'(N_CH);

    state_t              state;
    logic [CNT_W-1:0]    cnt;       // cycles remaining in WINDOW / CLEAR
    logic [7:0]          sel;       // channel being sampled; N_CH means "emit trailer"
    logic                zs_q;
    logic                trig_q;
    logic [TIME_W-1:0]   event_num;
    logic [TIME_W-1:0]   n_data;
    logic                sel_hit;
    logic [TIME_W-1:0]   sel_time;

    function automatic logic [WORD_W-1:0] mk_word(
        input logic [TIME_W-1:0] payload,
        input logic [ID_W-1:0]   id
    );
        return WORD_W'(pack_word(PAYLOAD_MAX_W'(payload), id));
    endfunction

    chan_select #(
        .N_CH   (N_CH),
        .TIME_W (TIME_W)
    ) u_chan_select (
        .idx      (sel),
        .ch_hit   (ch_hit),
        .ch_time  (ch_time),
        .sel_hit  (sel_hit),
        .sel_time (sel_time)
    );

    assign gate     = (state == ST_WINDOW);
    assign tube_clr = (state == ST_CLEAR);
    assign busy     = (state != ST_IDLE);

    // The state names track what is on the FIFO port: HEADER while the header
    // is presented, SCAN while data slots are presented, TRAILER while the
    // trailer is presented. Each word is registered one cycle ahead, so the
    // channel sampled through chan_select is the one that appears next cycle.
    always_ff @(posedge clk50) begin
        if (rst) begin
            state      <= ST_CLEAR;
            cnt        <= CLR_LOAD;
            sel        <= '0;
            zs_q       <= 1'b0;
            trig_q     <= 1'b0;
            event_num  <= '0;
            n_data     <= '0;
            fifo_din   <= '0;
            fifo_wr_en <= 1'b0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            trig_q     <= trig;
            fifo_wr_en <= 1'b0;
            if (fifo_wr_en && fifo_full) begin
                overflow <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (trig && !trig_q) begin
                        zs_q  <= zs_en;
                        cnt   <= WIN_LOAD;
                        state <= ST_WINDOW;
                    end
                end

                ST_WINDOW: begin
                    if (cnt == '0) begin
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_CHECK: begin
                    // Whole event (header + N_CH data + trailer) must fit, else drop it.
                    if ({1'b0, fifo_space} < MIN_SPACE) begin
                        if (drop_cnt != 16'hFFFF) begin
                            drop_cnt <= drop_cnt + 16'd1;
                        end
                        event_num <= event_num + TIME_W'(1);
                        cnt       <= CLR_LOAD;
                        state     <= ST_CLEAR;
                    end else begin
                        fifo_din   <= mk_word(event_num, ID_HEADER);
                        fifo_wr_en <= 1'b1;
                        sel        <= '0;
                        n_data     <= '0;
                        state      <= ST_HEADER;
                    end
                end

                ST_HEADER, ST_SCAN: begin
                    if (sel == SEL_END) begin
                        fifo_din   <= mk_word(n_data, ID_TRAILER);
                        fifo_wr_en <= 1'b1;
                        state      <= ST_TRAILER;
                    end else begin
                        // Suppressed channels keep their slot so event latency is fixed.
                        if (!zs_q || sel_hit) begin
                            fifo_din   <= mk_word(sel_time, sel);
                            fifo_wr_en <= 1'b1;
                            n_data     <= n_data + TIME_W'(1);
                        end
                        sel   <= sel + 8'd1;
                        state <= ST_SCAN;
                    end
                end

                ST_TRAILER: begin
                    event_num <= event_num + TIME_W'(1);
                    cnt       <= CLR_LOAD;
                    state     <= ST_CLEAR;
                end

                ST_CLEAR: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                default: begin
                    cnt   <= CLR_LOAD;
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule
